sdram_frame_arbiter: RTL and testbench
======================================

SDRAM_FRAME_ARBITER -- requirements
Module: sdram_frame_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, SDRAM word address width.
REQ-002 SHALL have parameter BURST_LEN, default 8, 128-bit words per burst (power of two).
REQ-003 SHALL have parameter FRAME_WORDS, default 26112, 128-bit words per 480x272 frame at 5 pixels/word.
REQ-004 SHALL have parameter RD_THRESH, default 248, and RD_URGENT, default 32, display FIFO levels in words.
REQ-005 SHALL have port sdram_clk, in, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port sdram_rst, in, 1, asynchronous active-high reset.
REQ-007 SHALL have port rd_addr_set, in, 1, single-cycle pulse (already synchronised) that restarts the display read frame.
REQ-008 SHALL have port rd_fifo_level, in, 9, occupancy of the display read FIFO.
REQ-009 SHALL have port wr_frame_start, in, 1, single-cycle pulse that restarts the loader write frame.
REQ-010 SHALL have port wr_fifo_level, in, 9, occupancy of the loader write FIFO.
REQ-011 SHALL have ports cmd_valid out 1, cmd_ready in 1, cmd_wr out 1, cmd_addr out ADDR_W: burst command to the SDRAM controller.
REQ-012 SHALL have port burst_done, in, 1, single-cycle pulse when the accepted burst has finished.
REQ-013 SHALL have port busy, out, 1, high whenever the state is not IDLE.

Function
REQ-014 Read request SHALL be asserted when rd_fifo_level <= RD_THRESH; write request SHALL be asserted when wr_fifo_level >= BURST_LEN.
REQ-015 States SHALL be IDLE, RD_CMD, RD_WAIT, WR_CMD and WR_WAIT.
REQ-016 From IDLE, if rd_fifo_level < RD_URGENT, read SHALL win unconditionally.
REQ-017 Otherwise, if both are requesting, the port not granted last SHALL win (round-robin); a single requester SHALL win; with no request the block SHALL stay in IDLE.
REQ-018 Grant SHALL move IDLE->RD_CMD or IDLE->WR_CMD one cycle after evaluation; cmd_valid SHALL be registered high in the *_CMD state.
REQ-019 cmd_wr SHALL be 0 for read and 1 for write; cmd_addr SHALL equal the granted port's address register.
REQ-020 cmd_valid, cmd_wr and cmd_addr SHALL be held stable until the cycle in which cmd_valid&cmd_ready is true; that cycle SHALL move *_CMD->*_WAIT and deassert cmd_valid the next cycle.
REQ-021 *_WAIT SHALL return to IDLE on burst_done; burst_done in any other state SHALL be ignored.
REQ-022 On handshake, the granted address SHALL advance by BURST_LEN; if the result >= FRAME_WORDS it SHALL wrap to 0.
REQ-023 The last-grant flag SHALL update on handshake.
REQ-024 rd_addr_set SHALL clear the read address immediately when in IDLE, WR_CMD or WR_WAIT.
REQ-025 If rd_addr_set arrives in RD_CMD or RD_WAIT, it SHALL be latched as pending and applied on entry to IDLE, taking precedence over that burst's increment.
REQ-026 wr_frame_start SHALL behave symmetrically for the write address in WR_CMD/WR_WAIT.
REQ-027 A reset pulse coinciding with a handshake on the same port SHALL result in address 0.
REQ-028 An outstanding burst SHALL never be aborted; the maximum bursts in flight SHALL be one.

Reset
REQ-029 sdram_rst SHALL force IDLE, with cmd_valid=0, cmd_wr=0, cmd_addr=0, busy=0, both addresses=0, both pending flags=0, last-grant=write (so read wins first tie), asynchronously.
REQ-030 Reset mid-burst SHALL drop the command immediately; the SDRAM controller shares the same reset.

Structure
REQ-031 State encoding, BURST_LEN and FRAME_WORDS defaults SHALL live in a shared package, sdram_arb_pkg.
REQ-032 One sub-module, frame_addr_gen (address register, increment/wrap, pending-clear), SHALL be instantiated twice (read, write).

Verification
REQ-033 rd_fifo_level=0, wr_fifo_level=0, cmd_ready=1: expect read command at addr 0, then 8, 16, one per burst_done.
REQ-034 Both requesting, rd level=100: expect alternating R,W,R,W grants; cmd_addr each advancing by 8.
REQ-035 rd level=10 (urgent), write requesting, last grant=write: expect four consecutive reads, no write.
REQ-036 Read address at 26104, handshake: next read cmd_addr=0.
REQ-037 rd_addr_set during RD_WAIT at addr 40: after burst_done, next read cmd_addr=0, not 48.
REQ-038 cmd_ready held low for 5 cycles: cmd_valid/addr stable for all 5; sdram_rst mid-RD_WAIT -> cmd_valid=0, busy=0 asynchronously.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM frame arbiter: FSM states and frame geometry defaults.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        WR_CMD,
        WR_WAIT
    } arb_state_t;

    localparam int unsigned DEF_BURST_LEN   = 8;
    localparam int unsigned DEF_FRAME_WORDS = 26112;

endpackage

// File: rtl/frame_addr_gen.sv
// Per-port frame address register: advances one burst per handshake, wraps at frame end,
// and defers a restart that arrives while its own burst is in progress.
module frame_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              active,
    input  logic              advance,
    input  logic              finish,
    output logic [ADDR_W-1:0] addr
);

    logic              pending;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        sum       = {1'b0, addr} + (ADDR_W+1)'(BURST_LEN);
        next_addr = (sum >= (ADDR_W+1)'(FRAME_WORDS)) ? '0 : sum[ADDR_W-1:0];
    end

    // A restart during this port's own burst is held and wins over that burst's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            pending <= 1'b0;
        end else if (!active) begin
            if (restart) addr <= '0;
            pending <= 1'b0;
        end else if (advance) begin
            addr <= restart ? '0 : next_addr;
        end else if (finish) begin
            if (restart || pending) addr <= '0;
            pending <= 1'b0;
        end else if (restart) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates single-burst SDRAM access between the display read path and the loader write path,
// with an urgency override for a nearly empty display FIFO and round-robin otherwise.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned RD_THRESH   = 248,
    parameter int unsigned RD_URGENT   = 32
) (
    input  logic              sdram_clk,
    input  logic              sdram_rst,
    input  logic              rd_addr_set,
    input  logic [8:0]        rd_fifo_level,
    input  logic              wr_frame_start,
    input  logic [8:0]        wr_fifo_level,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic              busy
);

    localparam logic [8:0] RD_THRESH_L = 9'(RD_THRESH);
    localparam logic [8:0] RD_URGENT_L = 9'(RD_URGENT);
    localparam logic [8:0] WR_MIN_L    = 9'(BURST_LEN);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              last_wr;
    logic              rd_req;
    logic              wr_req;
    logic              rd_urgent;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign rd_req    = (rd_fifo_level <= RD_THRESH_L);
    assign wr_req    = (wr_fifo_level >= WR_MIN_L);
    assign rd_urgent = (rd_fifo_level < RD_URGENT_L);

    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            state   <= IDLE;
            last_wr <= 1'b1;
        end else begin
            state <= state_next;
            if (cmd_valid && cmd_ready) last_wr <= (state == WR_CMD);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_urgent)             state_next = RD_CMD;
                else if (rd_req && wr_req) state_next = last_wr ? RD_CMD : WR_CMD;
                else if (rd_req)           state_next = RD_CMD;
                else if (wr_req)           state_next = WR_CMD;
            end
            RD_CMD:  if (cmd_ready)  state_next = RD_WAIT;
            RD_WAIT: if (burst_done) state_next = IDLE;
            WR_CMD:  if (cmd_ready)  state_next = WR_WAIT;
            WR_WAIT: if (burst_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        busy      = (state != IDLE);
        case (state)
            RD_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = rd_addr;
            end
            WR_CMD: begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b1;
                cmd_addr  = wr_addr;
            end
            default: ;
        endcase
    end

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_rd_addr (
        .clk     (sdram_clk),
        .rst     (sdram_rst),
        .restart (rd_addr_set),
        .active  ((state == RD_CMD) || (state == RD_WAIT)),
        .advance ((state == RD_CMD) && cmd_ready),
        .finish  ((state == RD_WAIT) && burst_done),
        .addr    (rd_addr)
    );

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS)
    ) u_wr_addr (
        .clk     (sdram_clk),
        .rst     (sdram_rst),
        .restart (wr_frame_start),
        .active  ((state == WR_CMD) || (state == WR_WAIT)),
        .advance ((state == WR_CMD) && cmd_ready),
        .finish  ((state == WR_WAIT) && burst_done),
        .addr    (wr_addr)
    );

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter: fixed grant/address table, hand-built corner sequences,
// and randomized bursts checked against a transaction-level arbitration/address model.
module tb_sdram_frame_arbiter;

    localparam int ADDR_W = 24;
    localparam int BL     = 8;
    localparam int FW     = 26112;
    localparam int RT     = 248;
    localparam int RU     = 32;

    logic              sdram_clk;
    logic              sdram_rst;
    logic              rd_addr_set;
    logic [8:0]        rd_fifo_level;
    logic              wr_frame_start;
    logic [8:0]        wr_fifo_level;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic              burst_done;
    logic              busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [8:0]  rl;
        logic [8:0]  wl;
        logic        ew;
        logic [23:0] ea;
    } vec_t;

    sdram_frame_arbiter #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW),
        .RD_THRESH   (RT),
        .RD_URGENT   (RU)
    ) dut (
        .sdram_clk      (sdram_clk),
        .sdram_rst      (sdram_rst),
        .rd_addr_set    (rd_addr_set),
        .rd_fifo_level  (rd_fifo_level),
        .wr_frame_start (wr_frame_start),
        .wr_fifo_level  (wr_fifo_level),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .burst_done     (burst_done),
        .busy           (busy)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sdram_rst      = 1'b1;
        rd_fifo_level  = 9'd511;
        wr_fifo_level  = 9'd0;
        cmd_ready      = 1'b0;
        burst_done     = 1'b0;
        rd_addr_set    = 1'b0;
        wr_frame_start = 1'b0;
        repeat (2) @(negedge sdram_clk);
        sdram_rst = 1'b0;
        @(negedge sdram_clk);
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        while (!cmd_valid && n < 20) begin
            @(negedge sdram_clk);
            n++;
        end
        chk("cmd_seen", 32'(cmd_valid), 32'd1);
    endtask

    // pulses: [0] rd idle, [1] wr idle, [2] rd at handshake, [3] wr at handshake, [4] rd in wait, [5] wr in wait
    task automatic do_txn(input logic [8:0] rl, input logic [8:0] wl, input int stall, input int wcyc,
                          input logic [5:0] pulses, input logic exp_wr, input logic [23:0] exp_addr);
        logic [23:0] held;
        if (pulses[1:0] != 2'b00) begin
            rd_addr_set    = pulses[0];
            wr_frame_start = pulses[1];
            @(negedge sdram_clk);
            rd_addr_set    = 1'b0;
            wr_frame_start = 1'b0;
        end
        rd_fifo_level = rl;
        wr_fifo_level = wl;
        wait_cmd();
        if (!cmd_valid) begin
            rd_fifo_level = 9'd511;
            wr_fifo_level = 9'd0;
            return;
        end
        chk("cmd_wr", 32'(cmd_wr), 32'(exp_wr));
        chk("cmd_addr", 32'(cmd_addr), 32'(exp_addr));
        held = cmd_addr;
        for (int i = 0; i < stall; i++) begin
            @(negedge sdram_clk);
            chk("cmd_hold", 32'({cmd_valid, cmd_wr, cmd_addr}), 32'({1'b1, exp_wr, held}));
        end
        cmd_ready      = 1'b1;
        rd_addr_set    = pulses[2];
        wr_frame_start = pulses[3];
        @(negedge sdram_clk);
        cmd_ready      = 1'b0;
        rd_fifo_level  = 9'd511;
        wr_fifo_level  = 9'd0;
        chk("cmd_drop", 32'({cmd_valid, busy}), 32'd1);
        rd_addr_set    = pulses[4];
        wr_frame_start = pulses[5];
        @(negedge sdram_clk);
        rd_addr_set    = 1'b0;
        wr_frame_start = 1'b0;
        repeat (wcyc) @(negedge sdram_clk);
        burst_done = 1'b1;
        @(negedge sdram_clk);
        burst_done = 1'b0;
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t tbl [17];
        int   m_rd, m_wr, m_last_wr, g, rl, wl, exp;
        logic [5:0] p;

        tbl[0]  = '{9'd100, 9'd100, 1'b0, 24'd0};
        tbl[1]  = '{9'd100, 9'd100, 1'b1, 24'd0};
        tbl[2]  = '{9'd0,   9'd0,   1'b0, 24'd8};
        tbl[3]  = '{9'd0,   9'd0,   1'b0, 24'd16};
        tbl[4]  = '{9'd0,   9'd0,   1'b0, 24'd24};
        tbl[5]  = '{9'd100, 9'd100, 1'b1, 24'd8};
        tbl[6]  = '{9'd100, 9'd100, 1'b0, 24'd32};
        tbl[7]  = '{9'd100, 9'd100, 1'b1, 24'd16};
        tbl[8]  = '{9'd10,  9'd100, 1'b0, 24'd40};
        tbl[9]  = '{9'd10,  9'd100, 1'b0, 24'd48};
        tbl[10] = '{9'd10,  9'd100, 1'b0, 24'd56};
        tbl[11] = '{9'd10,  9'd100, 1'b0, 24'd64};
        tbl[12] = '{9'd300, 9'd50,  1'b1, 24'd24};
        tbl[13] = '{9'd300, 9'd8,   1'b1, 24'd32};
        tbl[14] = '{9'd248, 9'd7,   1'b0, 24'd72};
        tbl[15] = '{9'd31,  9'd100, 1'b0, 24'd80};
        tbl[16] = '{9'd32,  9'd100, 1'b1, 24'd40};

        do_reset();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_wr", 32'(cmd_wr), 32'd0);
        chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 17; i++)
            do_txn(tbl[i].rl, tbl[i].wl, 0, 0, 6'b0, tbl[i].ew, tbl[i].ea);

        // no requester: stays idle, stray burst_done ignored
        rd_fifo_level = 9'd249;
        wr_fifo_level = 9'd7;
        burst_done    = 1'b1;
        @(negedge sdram_clk);
        burst_done = 1'b0;
        repeat (4) @(negedge sdram_clk);
        chk("no_req_idle", 32'({busy, cmd_valid}), 32'd0);
        rd_fifo_level = 9'd511;
        wr_fifo_level = 9'd0;

        // restart during RD_WAIT at address 40
        do_reset();
        for (int k = 0; k < 5; k++) do_txn(9'd0, 9'd0, 0, 0, 6'b0, 1'b0, 24'(k * 8));
        do_txn(9'd0, 9'd0, 0, 1, 6'b010000, 1'b0, 24'd40);
        do_txn(9'd0, 9'd0, 0, 0, 6'b0, 1'b0, 24'd0);
        do_txn(9'd0, 9'd0, 0, 0, 6'b0, 1'b0, 24'd8);

        // write restart coinciding with its own handshake
        do_reset();
        do_txn(9'd300, 9'd50, 0, 0, 6'b0, 1'b1, 24'd0);
        do_txn(9'd300, 9'd50, 0, 0, 6'b001000, 1'b1, 24'd8);
        do_txn(9'd300, 9'd50, 0, 0, 6'b0, 1'b1, 24'd0);

        // stall hold, then asynchronous reset in RD_CMD and RD_WAIT
        do_reset();
        do_txn(9'd0, 9'd0, 5, 0, 6'b0, 1'b0, 24'd0);
        rd_fifo_level = 9'd0;
        wait_cmd();
        cmd_ready = 1'b1;
        @(negedge sdram_clk);
        cmd_ready     = 1'b0;
        rd_fifo_level = 9'd511;
        chk("wait_busy", 32'(busy), 32'd1);
        #2 sdram_rst = 1'b1;
        #1 chk("async_rst_wait", 32'({busy, cmd_valid}), 32'd0);
        @(negedge sdram_clk);
        sdram_rst     = 1'b0;
        rd_fifo_level = 9'd0;
        wait_cmd();
        #1 sdram_rst = 1'b1;
        #1 chk("async_rst_cmd", 32'({busy, cmd_valid, cmd_addr}), 32'd0);
        @(negedge sdram_clk);
        do_reset();

        // frame wrap on the read port
        for (int k = 0; k <= FW / BL; k++)
            do_txn(9'd0, 9'd0, 0, 0, 6'b0, 1'b0, 24'((k == FW / BL) ? 0 : k * BL));

        // randomized bursts against the model
        do_reset();
        m_rd = 0;
        m_wr = 0;
        m_last_wr = 1;
        for (int it = 0; it < 300; it++) begin
            rl = int'($urandom_range(0, 511));
            wl = int'($urandom_range(0, 511));
            if (rl > RT && wl < BL) wl = int'($urandom_range(BL, 300));
            p = 6'b0;
            for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 7) == 0);
            if (p[0]) m_rd = 0;
            if (p[1]) m_wr = 0;
            if (rl < RU)                  g = 0;
            else if (rl <= RT && wl >= BL) g = m_last_wr ? 0 : 1;
            else if (rl <= RT)            g = 0;
            else                          g = 1;
            exp = g ? m_wr : m_rd;
            do_txn(9'(rl), 9'(wl), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   p, g[0], 24'(exp));
            if (g == 1) m_wr = (m_wr + BL >= FW) ? 0 : m_wr + BL;
            else        m_rd = (m_rd + BL >= FW) ? 0 : m_rd + BL;
            if (p[2] || p[4]) m_rd = 0;
            if (p[3] || p[5]) m_wr = 0;
            m_last_wr = g;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
